matrix_print_engine: RTL and testbench



---
 rtl/matrix_print_engine.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_matrix_print_engine.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_print_engine.sv
// Matrix print engine: fetches a matrix element by element (row-major) and
// streams it as formatted ASCII text over a valid/ready byte interface.
module matrix_print_engine #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIM_W     = 3,
    parameter int unsigned MAX_DIM   = 5,
    parameter int unsigned FIELD_W   = 4,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           matrix_id,
    input  logic [DIM_W-1:0]     dim_m,
    input  logic [DIM_W-1:0]     dim_n,
    output logic                 rd_req,
    output logic [2*DIM_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    input  logic                 rd_valid,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int unsigned MAG_W  = DATA_W + 1;
    localparam int unsigned ADDR_W = 2 * DIM_W;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NDIG   = 5;
    localparam logic [MAG_W-1:0] TEN = MAG_W'(10);
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_ZERO = 8'h30;

    typedef enum logic [2:0] {
        IDLE, HDR, ERRMSG, FETCH, CONV, EMIT, SEP, FIN
    } state_t;

    state_t              state, state_n;
    logic [3:0]          id_q, id_n;
    logic [DIM_W-1:0]    m_q, m_n, n_q, n_n;
    logic                bad_q, bad_n;
    logic [DIM_W-1:0]    row, row_n, col, col_n;
    logic                pending, pending_n;
    logic                neg, neg_n;
    logic [MAG_W-1:0]    mag, mag_n;
    logic [3:0]          digits [NDIG];
    logic [3:0]          digits_n [NDIG];
    logic [2:0]          ndig, ndig_n;
    logic [CNT_W-1:0]    idx, idx_n;
    logic [7:0]          out_data_n;
    logic                out_valid_n, rd_req_n, busy_n, done_n, err_n;
    logic [ADDR_W-1:0]   rd_addr_n;

    logic                can_load;
    logic [MAG_W-1:0]    ext;
    logic                data_neg;

    assign can_load = ~out_valid | out_ready;
    assign ext      = (SIGNED_EN != 0) ? {rd_data[DATA_W-1], rd_data} : {1'b0, rd_data};
    assign data_neg = (SIGNED_EN != 0) && rd_data[DATA_W-1];

    // Header bytes "M<id> <m>x<n>:\n"; dimensions print with up to two decimal digits
    logic [7:0] hdr [10];
    logic [3:0] hdr_len;
    logic [7:0] mv, nv;
    always_comb begin
        mv = 8'(m_q);
        nv = 8'(n_q);
        for (int i = 0; i < 10; i++) hdr[i] = CH_LF;
        hdr[0]  = 8'h4D;
        hdr[1]  = (id_q < 4'd10) ? (CH_ZERO + 8'(id_q)) : (8'h37 + 8'(id_q));
        hdr[2]  = CH_SP;
        hdr_len = 4'd3;
        if (mv >= 8'd10) begin
            hdr[hdr_len] = CH_ZERO + mv / 8'd10;
            hdr_len      = hdr_len + 4'd1;
        end
        hdr[hdr_len] = CH_ZERO + mv % 8'd10;
        hdr_len      = hdr_len + 4'd1;
        hdr[hdr_len] = 8'h78;
        hdr_len      = hdr_len + 4'd1;
        if (nv >= 8'd10) begin
            hdr[hdr_len] = CH_ZERO + nv / 8'd10;
            hdr_len      = hdr_len + 4'd1;
        end
        hdr[hdr_len] = CH_ZERO + nv % 8'd10;
        hdr_len      = hdr_len + 4'd1;
        hdr[hdr_len] = 8'h3A;
        hdr_len      = hdr_len + 4'd2;
    end

    // Field layout: pad spaces, optional '-', then digits MSB first
    logic [CNT_W-1:0] len, pad, pos;
    logic [2:0]       dsel;
    logic [7:0]       emit_byte;
    always_comb begin
        len  = CNT_W'(ndig) + CNT_W'(neg);
        pad  = (CNT_W'(FIELD_W) > len) ? (CNT_W'(FIELD_W) - len) : '0;
        pos  = idx - pad;
        dsel = 3'(len - CNT_W'(1) - pos);
        if (idx < pad)               emit_byte = CH_SP;
        else if (neg && pos == '0)   emit_byte = 8'h2D;
        else                         emit_byte = CH_ZERO + 8'(digits[dsel]);
    end

    always_comb begin
        state_n     = state;
        id_n        = id_q;
        m_n         = m_q;
        n_n         = n_q;
        bad_n       = bad_q;
        row_n       = row;
        col_n       = col;
        pending_n   = pending;
        neg_n       = neg;
        mag_n       = mag;
        digits_n    = digits;
        ndig_n      = ndig;
        idx_n       = idx;
        out_data_n  = out_data;
        out_valid_n = out_valid & ~out_ready;
        rd_req_n    = 1'b0;
        rd_addr_n   = rd_addr;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    id_n    = matrix_id;
                    m_n     = dim_m;
                    n_n     = dim_n;
                    bad_n   = (dim_m == '0) || (dim_n == '0) ||
                              (32'(dim_m) > MAX_DIM) || (32'(dim_n) > MAX_DIM);
                    row_n   = '0;
                    col_n   = '0;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    state_n = HDR;
                end
            end
            HDR: begin
                if (can_load) begin
                    out_data_n  = hdr[idx[3:0]];
                    out_valid_n = 1'b1;
                    if (idx == CNT_W'(hdr_len) - CNT_W'(1)) begin
                        idx_n   = '0;
                        state_n = bad_q ? ERRMSG : FETCH;
                    end else begin
                        idx_n = idx + CNT_W'(1);
                    end
                end
            end
            ERRMSG: begin
                if (can_load) begin
                    out_valid_n = 1'b1;
                    unique case (idx[1:0])
                        2'd0:    out_data_n = 8'h45;
                        2'd1:    out_data_n = 8'h52;
                        2'd2:    out_data_n = 8'h52;
                        default: out_data_n = CH_LF;
                    endcase
                    idx_n = idx + CNT_W'(1);
                    if (idx[1:0] == 2'd3) state_n = FIN;
                end
            end
            FETCH: begin
                // one fetch in flight; rd_valid only counts while it is pending
                if (!pending) begin
                    rd_req_n  = 1'b1;
                    rd_addr_n = ADDR_W'(row) * ADDR_W'(n_q) + ADDR_W'(col);
                    pending_n = 1'b1;
                end else if (rd_valid) begin
                    pending_n = 1'b0;
                    neg_n     = data_neg;
                    mag_n     = data_neg ? (~ext + MAG_W'(1)) : ext;
                    ndig_n    = '0;
                    state_n   = CONV;
                end
            end
            CONV: begin
                digits_n[ndig] = 4'(mag % TEN);
                mag_n          = mag / TEN;
                ndig_n         = ndig + 3'd1;
                if (mag < TEN) begin
                    idx_n   = '0;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (can_load) begin
                    out_data_n  = emit_byte;
                    out_valid_n = 1'b1;
                    if (idx == pad + len - CNT_W'(1)) begin
                        idx_n   = '0;
                        state_n = SEP;
                    end else begin
                        idx_n = idx + CNT_W'(1);
                    end
                end
            end
            SEP: begin
                if (can_load) begin
                    out_valid_n = 1'b1;
                    if (col == n_q - DIM_W'(1)) begin
                        out_data_n = CH_LF;
                        col_n      = '0;
                        if (row == m_q - DIM_W'(1)) begin
                            state_n = FIN;
                        end else begin
                            row_n   = row + DIM_W'(1);
                            state_n = FETCH;
                        end
                    end else begin
                        out_data_n = CH_SP;
                        col_n      = col + DIM_W'(1);
                        state_n    = FETCH;
                    end
                end
            end
            FIN: begin
                // wait for the last byte to leave before signalling completion
                if (can_load) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    err_n   = bad_q;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id_q      <= '0;
            m_q       <= '0;
            n_q       <= '0;
            bad_q     <= 1'b0;
            row       <= '0;
            col       <= '0;
            pending   <= 1'b0;
            neg       <= 1'b0;
            mag       <= '0;
            digits    <= '{default: 4'd0};
            ndig      <= '0;
            idx       <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            id_q      <= id_n;
            m_q       <= m_n;
            n_q       <= n_n;
            bad_q     <= bad_n;
            row       <= row_n;
            col       <= col_n;
            pending   <= pending_n;
            neg       <= neg_n;
            mag       <= mag_n;
            digits    <= digits_n;
            ndig      <= ndig_n;
            idx       <= idx_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            rd_req    <= rd_req_n;
            rd_addr   <= rd_addr_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_matrix_print_engine.sv
// Directed bench for matrix_print_engine: default build plus a FIELD_W=3
// build and an unsigned build for the field-overflow cases.
`timescale 1ns/1ps
module tb_matrix_print_engine;
    localparam int unsigned DIM_W = 3;

    logic             clk = 1'b0;
    logic             rst, start, start3, startu, inject;
    logic [3:0]       matrix_id;
    logic [DIM_W-1:0] dim_m, dim_n;
    logic             rd_req, rd_valid = 1'b0;
    logic [5:0]       rd_addr;
    logic [7:0]       rd_data = 8'h00;
    logic [7:0]       out_data;
    logic             out_valid, out_ready, busy, done, err;

    logic             rq3, rv3 = 1'b0, ov3, busy3, done3, err3;
    logic [5:0]       ra3;
    logic [7:0]       od3;
    logic             rqu, rvu = 1'b0, ovu, busyu, doneu, erru;
    logic [5:0]       rau;
    logic [7:0]       odu;
    logic [7:0]       elem1;

    int passed = 0;
    int checks = 0;

    matrix_print_engine dut (
        .clk(clk), .rst(rst), .start(start), .matrix_id(matrix_id),
        .dim_m(dim_m), .dim_n(dim_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .err(err)
    );

    matrix_print_engine #(.FIELD_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .matrix_id(matrix_id),
        .dim_m(dim_m), .dim_n(dim_n), .rd_req(rq3), .rd_addr(ra3),
        .rd_data(elem1), .rd_valid(rv3), .out_data(od3),
        .out_valid(ov3), .out_ready(1'b1), .busy(busy3),
        .done(done3), .err(err3)
    );

    matrix_print_engine #(.SIGNED_EN(0)) dutu (
        .clk(clk), .rst(rst), .start(startu), .matrix_id(matrix_id),
        .dim_m(dim_m), .dim_n(dim_n), .rd_req(rqu), .rd_addr(rau),
        .rd_data(elem1), .rd_valid(rvu), .out_data(odu),
        .out_valid(ovu), .out_ready(1'b1), .busy(busyu),
        .done(doneu), .err(erru)
    );

    always #5 clk = ~clk;

    // Element memory with programmable read latency, plus a stray-rd_valid injector
    logic [7:0] mem [64];
    int         lat = 1;
    int         pend_cnt = 0;
    logic [7:0] pend_data;
    logic [5:0] fetch_q [$];
    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if (rst) begin
            pend_cnt <= 0;
        end else if (rd_req) begin
            fetch_q.push_back(rd_addr);
            pend_data <= mem[rd_addr];
            pend_cnt  <= lat;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                rd_valid <= 1'b1;
                rd_data  <= pend_data;
            end
        end
        if (inject) begin
            rd_valid <= 1'b1;
            rd_data  <= 8'h77;
        end
    end

    always @(posedge clk) begin
        rv3 <= rq3;
        rvu <= rqu;
    end

    bit bp_en = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitors, sampled on the falling edge
    string      got, got3, gotu;
    int         done_cnt, err_at_done, busy_at_done, err_stray, stab_viol, stall_cnt;
    int         done3_cnt, doneu_cnt, cyc = 0;
    int         tcyc [$];
    logic       prev_v = 1'b0, prev_r = 1'b1;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) begin
            got = {got, $sformatf("%c", out_data)};
            tcyc.push_back(cyc);
        end
        if (out_valid && !out_ready) stall_cnt++;
        if (prev_v && !prev_r && !rst && (out_valid !== 1'b1 || out_data !== prev_d)) stab_viol++;
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
        if (done) begin
            done_cnt++;
            err_at_done  = int'(err);
            busy_at_done = int'(busy);
        end
        if (err && !done) err_stray++;
        if (ov3) got3 = {got3, $sformatf("%c", od3)};
        if (ovu) gotu = {gotu, $sformatf("%c", odu)};
        if (done3) done3_cnt++;
        if (doneu) doneu_cnt++;
    end

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "|"};
            else               r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    task automatic clear_mon();
        got = ""; got3 = ""; gotu = "";
        done_cnt = 0; err_at_done = 0; busy_at_done = 0; err_stray = 0;
        stab_viol = 0; stall_cnt = 0; done3_cnt = 0; doneu_cnt = 0;
        tcyc.delete();
        fetch_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic pulse_start(input logic [3:0] id, input logic [2:0] m, input logic [2:0] n,
                               output logic busy_pre);
        matrix_id = id;
        dim_m     = m;
        dim_n     = n;
        start     = 1'b1;
        @(negedge clk);
        busy_pre = busy;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data);
        else passed++;
        checks++;
        if (rd_req !== 1'b0 || rd_addr !== 6'd0)
            $display("FAIL reset_rd: got req=%b addr=%0d want 0/0", rd_req, rd_addr);
        else passed++;
        checks++;
        if ({busy, done, err} !== 3'b000)
            $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy, done, err});
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        string exp;
        logic  bp, b1;
        int    k;
        bit    ok;
        exp = "M2 2x2:\n   5  -12\n 100    0\n";
        mem[0] = 8'd5; mem[1] = 8'hF4; mem[2] = 8'd100; mem[3] = 8'd0;
        lat = 1;
        clear_mon();
        pulse_start(4'd2, 3'd2, 3'd2, bp);
        @(negedge clk);
        b1 = busy;
        k  = 1;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bp !== 1'b0 || b1 !== 1'b1)
            $display("FAIL basic_busy_rise: got before=%b after=%b want 0/1", bp, b1);
        else passed++;
        checks++;
        if (k > 2) $display("FAIL basic_first_valid: got %0d cycles want <=2", k);
        else passed++;
        wait_done(300, ok);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (!ok || got != exp) $display("FAIL basic_stream: got \"%s\" want \"%s\"", vis(got), vis(exp));
        else passed++;
        checks++;
        if (done_cnt != 1 || err_at_done != 0 || busy_at_done != 0)
            $display("FAIL basic_done: got done=%0d err=%0d busy=%0d want 1/0/0",
                     done_cnt, err_at_done, busy_at_done);
        else passed++;
        checks++;
        if (fetch_q.size() != 4 || fetch_q[0] != 6'd0 || fetch_q[1] != 6'd1 ||
            fetch_q[2] != 6'd2 || fetch_q[3] != 6'd3)
            $display("FAIL basic_fetch_order: got %0d fetches want 0,1,2,3", fetch_q.size());
        else passed++;
        checks++;
        if (tcyc.size() < 13) $display("FAIL basic_b2b: got %0d transfers want >=13", tcyc.size());
        else if (tcyc[7] - tcyc[0] != 7 || tcyc[12] - tcyc[8] != 4)
            $display("FAIL basic_b2b: got hdr span %0d field span %0d want 7/4",
                     tcyc[7] - tcyc[0], tcyc[12] - tcyc[8]);
        else passed++;
    endtask

    task automatic test_backpressure();
        string exp;
        logic  bp;
        bit    ok;
        exp = "M2 2x2:\n   5  -12\n 100    0\n";
        lat = 3;
        clear_mon();
        bp_en = 1'b1;
        pulse_start(4'd2, 3'd2, 3'd2, bp);
        wait_done(2000, ok);
        bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || got != exp) $display("FAIL bp_stream: got \"%s\" want \"%s\"", vis(got), vis(exp));
        else passed++;
        checks++;
        if (stab_viol != 0) $display("FAIL bp_stable: got %0d violations want 0", stab_viol);
        else passed++;
        checks++;
        if (stall_cnt == 0) $display("FAIL bp_stalled: got %0d stall cycles want >0", stall_cnt);
        else passed++;
        checks++;
        if (done_cnt != 1 || err_at_done != 0)
            $display("FAIL bp_done: got done=%0d err=%0d want 1/0", done_cnt, err_at_done);
        else passed++;
        lat = 1;
    endtask

    task automatic test_field_overflow();
        int n;
        clear_mon();
        elem1     = 8'h80;
        matrix_id = 4'd0;
        dim_m     = 3'd1;
        dim_n     = 3'd1;
        start3    = 1'b1;
        startu    = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        startu = 1'b0;
        n = 0;
        while ((done3_cnt == 0 || doneu_cnt == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got3 != "M0 1x1:\n-128\n") $display("FAIL ovf_signed: got \"%s\" want \"M0 1x1:|-128|\"", vis(got3));
        else passed++;
        checks++;
        if (gotu != "M0 1x1:\n 128\n") $display("FAIL ovf_unsigned: got \"%s\" want \"M0 1x1:| 128|\"", vis(gotu));
        else passed++;
        checks++;
        if (done3_cnt != 1 || doneu_cnt != 1)
            $display("FAIL ovf_done: got %0d/%0d want 1/1", done3_cnt, doneu_cnt);
        else passed++;
    endtask

    task automatic test_illegal();
        logic bp;
        bit   ok;
        clear_mon();
        pulse_start(4'd11, 3'd0, 3'd3, bp);
        wait_done(200, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || got != "MB 0x3:\nERR\n") $display("FAIL illegal_stream: got \"%s\" want \"MB 0x3:|ERR|\"", vis(got));
        else passed++;
        checks++;
        if (done_cnt != 1 || err_at_done != 1 || err_stray != 0)
            $display("FAIL illegal_err: got done=%0d err=%0d stray=%0d want 1/1/0",
                     done_cnt, err_at_done, err_stray);
        else passed++;
        checks++;
        if (fetch_q.size() != 0) $display("FAIL illegal_no_fetch: got %0d fetches want 0", fetch_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic bp;
        bit   ok;
        int   n;
        for (int i = 0; i < 9; i++) mem[i] = 8'(i + 1);
        clear_mon();
        pulse_start(4'd3, 3'd3, 3'd3, bp);
        n = 0;
        while (got.len() < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got.len() < 10) $display("FAIL rstmid_reach_emit: got %0d bytes want 10", got.len());
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0)
            $display("FAIL rstmid_cleared: got valid=%b busy=%b req=%b want 0/0/0", out_valid, busy, rd_req);
        else passed++;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        checks++;
        if (done_cnt != 0) $display("FAIL rstmid_no_done: got %0d want 0", done_cnt);
        else passed++;
        mem[0] = 8'hFD;
        clear_mon();
        pulse_start(4'd1, 3'd1, 3'd1, bp);
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        wait_done(300, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || got != "M1 1x1:\n  -3\n") $display("FAIL rstmid_next_job: got \"%s\" want \"M1 1x1:|  -3|\"", vis(got));
        else passed++;
        checks++;
        if (fetch_q.size() != 1 || done_cnt != 1)
            $display("FAIL rstmid_next_fetch: got fetches=%0d done=%0d want 1/1", fetch_q.size(), done_cnt);
        else passed++;
    endtask

    task automatic test_start_busy();
        string exp;
        logic  bp;
        bit    ok;
        int    addr_bad;
        exp = "M4 5x5:\n";
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                mem[r * 5 + c] = 8'(r * 5 + c);
                exp = {exp, $sformatf("%4d", r * 5 + c)};
                if (c == 4) exp = {exp, "\n"};
                else        exp = {exp, " "};
            end
        end
        clear_mon();
        pulse_start(4'd4, 3'd5, 3'd5, bp);
        repeat (20) @(posedge clk);
        #1;
        pulse_start(4'd9, 3'd1, 3'd1, bp);
        wait_done(3000, ok);
        repeat (40) @(posedge clk);
        #1;
        addr_bad = 0;
        for (int i = 0; i < fetch_q.size(); i++) if (fetch_q[i] != 6'(i)) addr_bad++;
        checks++;
        if (!ok || done_cnt != 1) $display("FAIL busy_one_done: got %0d done pulses want 1", done_cnt);
        else passed++;
        checks++;
        if (fetch_q.size() != 25 || addr_bad != 0)
            $display("FAIL busy_fetches: got %0d fetches, %0d out of order want 25/0", fetch_q.size(), addr_bad);
        else passed++;
        checks++;
        if (got != exp) $display("FAIL busy_stream: got \"%s\" want \"%s\"", vis(got), vis(exp));
        else passed++;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL busy_idle_after: got busy=%b valid=%b want 0/0", busy, out_valid);
        else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start3    = 1'b0;
        startu    = 1'b0;
        inject    = 1'b0;
        matrix_id = 4'd0;
        dim_m     = '0;
        dim_n     = '0;
        elem1     = 8'h00;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_field_overflow();
        test_illegal();
        test_reset_mid();
        test_start_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
